// File: rtl/seq_acc5.sv
// Sequential frame accumulator around the 5-bit csua adder: sums a stream of
// operands into {carry count, low 5 bits} and hands the result off per frame.

module csua (
  input  logic [4:0] x,
  input  logic [4:0] y,
  output logic [4:0] z,
  output logic       co
);
  logic [2:0] w_lo;
  logic [3:0] w_hi0;
  logic [3:0] w_hi1;
  logic [3:0] w_hi;

  // Carry-select: upper 3 bits are precomputed for both carry-ins.
  assign w_lo  = {1'b0, x[1:0]} + {1'b0, y[1:0]};
  assign w_hi0 = {1'b0, x[4:2]} + {1'b0, y[4:2]};
  assign w_hi1 = {1'b0, x[4:2]} + {1'b0, y[4:2]} + 4'd1;
  assign w_hi  = w_lo[2] ? w_hi1 : w_hi0;
  assign z     = {w_hi[2:0], w_lo[1:0]};
  assign co    = w_hi[3];
endmodule

module seq_acc5 #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W+4:0]   out_sum,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_ovf
);
  typedef enum logic {ACC, DONE} state_t;

  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("seq_acc5: CNT_W must be at least 2");
  end

  state_t           r_state;
  logic [4:0]       r_lo;
  logic [CNT_W-1:0] r_hi;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  state_t           w_state_next;
  logic [4:0]       w_lo_next;
  logic [CNT_W-1:0] w_hi_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf_next;
  logic [4:0]       w_z;
  logic             w_co;
  logic             w_accept;

  csua u_add (
    .x  (r_lo),
    .y  (in_data),
    .z  (w_z),
    .co (w_co)
  );

  assign w_accept = in_valid && (r_state == ACC);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ACC;
      r_lo    <= '0;
      r_hi    <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_lo    <= w_lo_next;
      r_hi    <= w_hi_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lo_next    = r_lo;
    w_hi_next    = r_hi;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf;
    case (r_state)
      ACC: begin
        if (w_accept) begin
          w_lo_next  = w_z;
          w_hi_next  = r_hi + {{(CNT_W-1){1'b0}}, w_co};
          w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
          // A carry into an all-ones high part means the widened sum wrapped.
          w_ovf_next = r_ovf | (w_co & (&r_hi));
          if (in_last) w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = ACC;
          w_lo_next    = '0;
          w_hi_next    = '0;
          w_cnt_next   = '0;
          w_ovf_next   = 1'b0;
        end
      end
      default: w_state_next = ACC;
    endcase
  end

  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == DONE);
  assign out_sum   = {r_hi, r_lo};
  assign out_count = r_cnt;
  assign out_ovf   = r_ovf;
endmodule
